// File: rtl/multicycle_ctrl.sv
// Moore main control FSM for the multicycle CPU datapath, with memory-latency stretching.
// Define MULTICYCLE_CTRL_ADDI_EN to build the addi path (ADDI_EX/ADDI_WB); otherwise addi halts.
module multicycle_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       halt,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [5:0] op_reg;
    logic       in_wait_state;
    logic       wait_done;

    assign in_wait_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                           (state_reg == S_MEMWR);
    assign wait_done     = (cnt_reg == WAIT_LAST);

    // State, wait counter and captured opcode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_FETCH;
            cnt_reg   <= 4'd0;
            op_reg    <= 6'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == S_DECODE) begin
                op_reg <= opcode;
            end
        end
    end

    // Counter returns to 0 whenever a wait state completes, so every entry starts at 0
    always_comb begin
        cnt_next   = 4'd0;
        state_next = state_reg;
        if (in_wait_state && !wait_done) begin
            cnt_next = cnt_reg + 4'd1;
        end
        case (state_reg)
            S_FETCH: begin
                if (wait_done) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_next = S_EXEC;
                    OP_LW, OP_SW:  state_next = S_MEMADR;
                    OP_BEQ:        state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:       state_next = S_ADDI_EX;
`endif
                    default:       state_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                state_next = (op_reg == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (wait_done) state_next = S_MEMWB;
            end
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR: begin
                if (wait_done) state_next = S_FETCH;
            end
            S_EXEC:   state_next = S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_ADDI_EX: state_next = S_ADDI_WB;
            S_ADDI_WB: state_next = S_FETCH;
`endif
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    // Moore outputs; rst gating keeps every strobe low asynchronously while reset is held
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halt          = 1'b0;
        if (rst) begin
            case (state_reg)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = wait_done;
                    pc_write  = wait_done;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
`ifdef MULTICYCLE_CTRL_ADDI_EN
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
`endif
                S_HALT: begin
                    halt = 1'b1;
                end
                default: begin
                    halt = 1'b0;
                end
            endcase
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three instances (MEM_LAT 1..3) checked cycle by cycle against
// expected state/control sequences expanded from per-instruction step lists.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       halt;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [3:0] state;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        logic       last;
        logic [5:0] drv;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opc [3];
    logic [20:0] obs [3];
    int          checks = 0;
    int          failures = 0;
    step_t       prog[$];
    bit          prog_halted;
    logic [5:0]  noise_tab [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                   6'b000010, 6'b001000, 6'b111111, 6'b010101};

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
            logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halt;
            logic [1:0] alu_src_b, alu_op, pc_source;
            logic [3:0] state;
            multicycle_ctrl #(.MEM_LAT(gi + 1)) u_dut (
                .clk(clk), .rst(rst), .opcode(opc[gi]),
                .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
                .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
                .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
                .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
                .pc_source(pc_source), .halt(halt), .state(state)
            );
            assign obs[gi] = {halt, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                              ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                              alu_src_b, alu_op, pc_source, state};
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Control word each state must present
    function automatic ctl_t expect_ctl(input logic [3:0] st, input logic last);
        ctl_t c = '0;
        c.state = st;
        case (st)
            4'd0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = last; c.pc_write = last; end
            4'd1:  c.alu_src_b = 2'b11;
            4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4'd4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            4'd5:  begin c.mem_write = 1; c.i_or_d = 1; end
            4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            4'd7:  begin c.reg_write = 1; c.reg_dst = 1; end
            4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            4'd9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
            4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd11: c.reg_write = 1;
            4'd12: c.halt = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [5:0] noise();
        if ($urandom_range(0, 1) == 0) return noise_tab[$urandom_range(0, 7)];
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic [5:0] rand_legal();
        case ($urandom_range(0, 4))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            default: return 6'b000010;
        endcase
    endfunction

    task automatic push_step(input logic [3:0] st, input logic last, input logic [5:0] drv);
        step_t s;
        s.st = st; s.last = last; s.drv = drv;
        prog.push_back(s);
    endtask

    task automatic add_wait(input int l, input logic [3:0] st);
        for (int k = 0; k < l; k++) push_step(st, k == l - 1, noise());
    endtask

    task automatic add_halt();
        for (int k = 0; k < 21; k++) push_step(4'd12, 1'b0, noise());
        prog_halted = 1;
    endtask

    task automatic add_instr(input int l, input logic [5:0] op);
        if (prog_halted) return;
        add_wait(l, 4'd0);
        push_step(4'd1, 1'b0, op);
        case (op)
            6'b000000: begin push_step(4'd6, 0, noise()); push_step(4'd7, 0, noise()); end
            6'b100011: begin push_step(4'd2, 0, noise()); add_wait(l, 4'd3); push_step(4'd4, 0, noise()); end
            6'b101011: begin push_step(4'd2, 0, noise()); add_wait(l, 4'd5); end
            6'b000100: push_step(4'd8, 0, noise());
            6'b000010: push_step(4'd9, 0, noise());
`ifdef MULTICYCLE_CTRL_ADDI_EN
            6'b001000: begin push_step(4'd10, 0, noise()); push_step(4'd11, 0, noise()); end
`endif
            default:   add_halt();
        endcase
    endtask

    task automatic new_prog();
        prog.delete();
        prog_halted = 0;
    endtask

    // Entered just after a negedge; each step is checked 2 time units later
    task automatic run_prog(input int lane, input int n);
        for (int i = 0; i < n; i++) begin
            #2;
            check($sformatf("L%0d step%0d st%0d", lane + 1, i, prog[i].st), 32'(obs[lane]),
                  32'(expect_ctl(prog[i].st, prog[i].last)));
            opc[lane] = prog[i].drv;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int l = 0; l < 3; l++) opc[l] = noise();
        @(negedge clk);
        #2;
        for (int l = 0; l < 3; l++) check($sformatf("in_reset L%0d", l + 1), 32'(obs[l]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        for (int l = 0; l < 3; l++) opc[l] = 6'd0;
        @(negedge clk);

        // Each latency: directed instruction mix, random legal stream, then halt with opcode noise
        for (int lane = 0; lane < 3; lane++) begin
            do_reset();
            new_prog();
            add_instr(lane + 1, 6'b000000);
            add_instr(lane + 1, 6'b100011);
            add_instr(lane + 1, 6'b101011);
            add_instr(lane + 1, 6'b000100);
            add_instr(lane + 1, 6'b000010);
            for (int k = 0; k < 10; k++) add_instr(lane + 1, rand_legal());
            if (lane == 0) add_instr(1, 6'b001000);
            add_instr(lane + 1, 6'b111111);
            run_prog(lane, prog.size());
        end

        // Illegal opcode halts
        do_reset();
        new_prog();
        add_instr(1, 6'b010101);
        run_prog(0, prog.size());

        // Reset asserted during MEMRD wait cycle 1 at MEM_LAT=3
        do_reset();
        new_prog();
        add_instr(3, 6'b100011);
        run_prog(2, 6);
        #2;
        check("memrd_wait1 before drop", 32'(obs[2]), 32'(expect_ctl(4'd3, 1'b0)));
        rst = 1'b0;
        #1;
        for (int l = 0; l < 3; l++) check($sformatf("async_drop L%0d", l + 1), 32'(obs[l]), 32'd0);
        @(negedge clk);
        #2;
        check("held_reset L3", 32'(obs[2]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        new_prog();
        add_instr(3, 6'b000000);
        add_instr(3, 6'b101011);
        run_prog(2, prog.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
